// File: rtl/encoder_8b10b_multicanal.sv
// ---------------------------------------------------------------------------
// encoder_8b10b_multicanal
//   Multi-lane 8b/10b encoder. Each clock it encodes LANES byte+K pairs into
//   10-bit codes, with running disparity chained lane 0 -> LANES-1 and carried
//   between cycles in the rd register. One register stage, no back-pressure.
//   On idle (enb=0) every lane emits K28.5 when IDLE_COMMA=1, otherwise the
//   outputs and rd hold.
//
//   Optional macro ENC_CODE_ERR_EN: adds the err port, flagging lanes that
//   asked for an illegal K code (that byte is still encoded as data).
//
// Ports
//   clk       in   clock, posedge
//   rst       in   asynchronous reset, active high
//   enb       in   input valid; entradas/K sampled when 1
//   entradas  in   [8*LANES-1:0]  lane n byte at [8n+7:8n], HGF EDCBA
//   K         in   [LANES-1:0]    lane n is a control symbol
//   salidas   out  [10*LANES-1:0] lane n code at [10n+9:10n], bit9=a .. bit0=j
//   valid     out  salidas carry a code from a sampled enb cycle
//   rd        out  RD after last lane (0=RD-, 1=RD+)
//   err       out  [LANES-1:0]    (ENC_CODE_ERR_EN) illegal K requested
// ---------------------------------------------------------------------------

// Per-lane encoder. Produces the code for both possible incoming RD values so
// the lane chain in the top only has to pick, not re-encode, per lane.
module encoder_8b10b_lane (
  input  logic [7:0] dato_i,
  input  logic       k_i,
  output logic [9:0] code_n_o,   // code when entering at RD-
  output logic       rd_n_o,     // RD after this lane when entering at RD-
  output logic [9:0] code_p_o,   // code when entering at RD+
  output logic       rd_p_o
`ifdef ENC_CODE_ERR_EN
  , output logic     kerr_o
`endif
);

  function automatic logic legal_k(input logic [7:0] d, input logic k);
    logic [4:0] x;
    logic [2:0] y;
    x = d[4:0];
    y = d[7:5];
    return k && ((x == 5'd28) ||
                 ((y == 3'd7) && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30)));
  endfunction

  // Returns {rd_out, abcdei, fghj}.
  function automatic logic [10:0] enc(input logic [7:0] d, input logic k, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic       kok, rd6, a7;
    logic [5:0] c6;
    logic [3:0] c4;
    x   = d[4:0];
    y   = d[7:5];
    kok = legal_k(d, k);
    // 5b/6b, RD- column
    case (x)
      5'd0:  c6 = 6'b100111;  5'd1:  c6 = 6'b011101;
      5'd2:  c6 = 6'b101101;  5'd3:  c6 = 6'b110001;
      5'd4:  c6 = 6'b110101;  5'd5:  c6 = 6'b101001;
      5'd6:  c6 = 6'b011001;  5'd7:  c6 = 6'b111000;
      5'd8:  c6 = 6'b111001;  5'd9:  c6 = 6'b100101;
      5'd10: c6 = 6'b010101;  5'd11: c6 = 6'b110100;
      5'd12: c6 = 6'b001101;  5'd13: c6 = 6'b101100;
      5'd14: c6 = 6'b011100;  5'd15: c6 = 6'b010111;
      5'd16: c6 = 6'b011011;  5'd17: c6 = 6'b100011;
      5'd18: c6 = 6'b010011;  5'd19: c6 = 6'b110010;
      5'd20: c6 = 6'b001011;  5'd21: c6 = 6'b101010;
      5'd22: c6 = 6'b011010;  5'd23: c6 = 6'b111010;
      5'd24: c6 = 6'b110011;  5'd25: c6 = 6'b100110;
      5'd26: c6 = 6'b010110;  5'd27: c6 = 6'b110110;
      5'd28: c6 = 6'b001110;  5'd29: c6 = 6'b101110;
      5'd30: c6 = 6'b011110;  5'd31: c6 = 6'b101011;
    endcase
    if (kok && x == 5'd28) c6 = 6'b001111;
    // RD+ column is the complement for unbalanced codes and for D.7,
    // the one balanced 6b code that still alternates
    if (rd && (($countones(c6) != 3) || (c6 == 6'b111000))) c6 = ~c6;
    rd6 = rd ^ ($countones(c6) != 3);
    // A7 avoids a run of five across the e,i / f,g boundary
    a7 = rd6 ? (c6[1:0] == 2'b00) : (c6[1:0] == 2'b11);
    if (kok) begin
      case (y)
        3'd0: c4 = 4'b1011;  3'd1: c4 = 4'b0110;
        3'd2: c4 = 4'b1010;  3'd3: c4 = 4'b1100;
        3'd4: c4 = 4'b1101;  3'd5: c4 = 4'b0101;
        3'd6: c4 = 4'b1001;  3'd7: c4 = 4'b0111;
      endcase
      // every control 4b code alternates with RD, balanced or not
      if (rd6) c4 = ~c4;
    end else begin
      case (y)
        3'd0: c4 = 4'b1011;  3'd1: c4 = 4'b1001;
        3'd2: c4 = 4'b0101;  3'd3: c4 = 4'b1100;
        3'd4: c4 = 4'b1101;  3'd5: c4 = 4'b1010;
        3'd6: c4 = 4'b0110;  3'd7: c4 = a7 ? 4'b0111 : 4'b1110;
      endcase
      if (rd6 && (($countones(c4) != 2) || (y == 3'd3))) c4 = ~c4;
    end
    return {rd6 ^ ($countones(c4) != 2), c6, c4};
  endfunction

  assign {rd_n_o, code_n_o} = enc(dato_i, k_i, 1'b0);
  assign {rd_p_o, code_p_o} = enc(dato_i, k_i, 1'b1);
`ifdef ENC_CODE_ERR_EN
  assign kerr_o = k_i && !legal_k(dato_i, k_i);
`endif

endmodule

module encoder_8b10b_multicanal #(
  parameter int LANES      = 1,
  parameter int IDLE_COMMA = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enb,
  input  logic [8*LANES-1:0]    entradas,
  input  logic [LANES-1:0]      K,
  output logic [10*LANES-1:0]   salidas,
  output logic                  valid,
  output logic                  rd
`ifdef ENC_CODE_ERR_EN
  , output logic [LANES-1:0]    err
`endif
);

  logic [LANES-1:0][9:0] code_n, code_p, salidas_d, salidas_q;
  logic [LANES-1:0]      rdo_n, rdo_p;
  logic                  rd_d, rd_q, valid_q;
`ifdef ENC_CODE_ERR_EN
  logic [LANES-1:0]      kerr, err_q;
`endif

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    logic [7:0] dat;
    logic       kk;
    // idle lanes encode K28.5
    assign dat = enb ? entradas[8*n +: 8] : 8'hBC;
    assign kk  = enb ? K[n] : 1'b1;
    encoder_8b10b_lane u_lane (
      .dato_i   (dat),
      .k_i      (kk),
      .code_n_o (code_n[n]),
      .rd_n_o   (rdo_n[n]),
      .code_p_o (code_p[n]),
      .rd_p_o   (rdo_p[n])
`ifdef ENC_CODE_ERR_EN
      , .kerr_o (kerr[n])
`endif
    );
  end

  // RD ripple: each lane selects its precomputed code with the RD left by
  // the previous lane; lane 0 starts from the registered rd.
  always_comb begin
    rd_d      = rd_q;
    salidas_d = '0;
    for (int n = 0; n < LANES; n++) begin
      salidas_d[n] = rd_d ? code_p[n] : code_n[n];
      rd_d         = rd_d ? rdo_p[n] : rdo_n[n];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      salidas_q <= '0;
      valid_q   <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      valid_q <= enb;
      if (enb || (IDLE_COMMA != 0)) begin
        salidas_q <= salidas_d;
        rd_q      <= rd_d;
      end
    end
  end

`ifdef ENC_CODE_ERR_EN
  // idle lanes feed K28.5, which is legal, so err clears on idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= kerr;
  end
  assign err = err_q;
`endif

  assign salidas = salidas_q;
  assign valid   = valid_q;
  assign rd      = rd_q;

endmodule
